bus_mem_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_mem_array.sv | 37 +++
 rtl/bus_mem_responder.sv | 109 ++++++++++
 tb/tb_bus_mem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus_if target-side responder.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_resp_state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bus_mem_array.sv
// Word storage for the responder: synchronous write, registered read data,
// whole array and read register cleared by reset.
module bus_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // A cleared read returns zero; otherwise rdata holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[idx] <= wdata;
            end
            if (rd_en) begin
                rdata <= mem[idx];
            end else if (rd_clr) begin
                rdata <= '0;
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// bus_if target: latches a request, waits WAIT_CYCLES, then answers with a
// one-cycle ready pulse; reads/writes a local word array, flags decode errors.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    bus_resp_state_e   state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              cur_rw_c;
    logic [ADDR_W-1:0] cur_addr_c;
    logic [DATA_W-1:0] cur_wdata_c;
    logic              cur_err_c;
    logic              go_resp_c;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
    endfunction

    // With zero wait states the array is accessed on the acceptance edge
    // itself, so the live request is used before it has been latched.
    always_comb begin
        cur_rw_c    = lat_rw;
        cur_addr_c  = lat_addr;
        cur_wdata_c = lat_wdata;
        if (state == IDLE) begin
            cur_rw_c    = rw;
            cur_addr_c  = addr;
            cur_wdata_c = wdata;
        end
        cur_err_c = addr_err(cur_addr_c);
        go_resp_c = ((state == IDLE) && valid && (WAIT_CYCLES == 0))
                 || ((state == WAIT) && (cnt == CNT_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_rw    <= RW_READ;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        lat_rw    <= rw;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    ready <= 1'b1;
                    err   <= addr_err(lat_addr);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bus_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (go_resp_c && (cur_rw_c == RW_WRITE) && !cur_err_c),
        .rd_en  (go_resp_c && (cur_rw_c == RW_READ) && !cur_err_c),
        .rd_clr (go_resp_c && cur_err_c),
        .idx    (cur_addr_c[IDX_W+1:2]),
        .wdata  (cur_wdata_c),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Randomized self-checking bench: one responder with 2 wait states, one with 0,
// both compared against a transaction-level memory model.
module tb_bus_mem_responder;

    localparam int unsigned WC0 = 2;
    localparam int unsigned WC1 = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       valid;
    logic [1:0]       rw;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       ready;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [2][64];
    logic [31:0] rd_m  [2];

    always #5 clk = ~clk;

    bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(WC0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .valid(valid[0]), .rw(rw[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
    );

    bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(WC1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .valid(valid[1]), .rw(rw[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned wcyc(input int d);
        return (d == 0) ? WC0 : WC1;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            rd_m[d] = '0;
            for (int i = 0; i < 64; i++) mem_m[d][i] = '0;
        end
    endfunction

    // Applies one completed transaction to the model and returns the expected err.
    function automatic logic model_apply(input int d, input logic r, input logic [31:0] a,
                                         input logic [31:0] wd);
        if (is_err(a)) begin
            rd_m[d] = '0;
            return 1'b1;
        end
        if (r) mem_m[d][a / 4] = wd;
        else   rd_m[d] = mem_m[d][a / 4];
        return 1'b0;
    endfunction

    task automatic do_txn(input int d, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input bit scramble);
        int  lat;
        bit  got;
        logic exp_err;
        @(negedge clk);
        valid[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        lat = 999;
        got = 0;
        for (int k = 0; k <= int'(wcyc(d)) + 6 && !got; k++) begin
            @(negedge clk);
            if (ready[d]) begin
                got = 1;
                lat = k;
            end else if (scramble && (k + 1) <= int'(wcyc(d))) begin
                valid[d] = 1'b1;
                rw[d]    = 1'($urandom_range(0, 1));
                addr[d]  = $urandom;
                wdata[d] = $urandom;
            end else begin
                valid[d] = 1'b0;
            end
        end
        valid[d] = 1'b0;
        exp_err = model_apply(d, r, a, wd);
        check($sformatf("latency d%0d a%08h", d, a), 32'(lat), 32'(wcyc(d) + 1));
        check($sformatf("err d%0d a%08h", d, a), 32'(err[d]), 32'(exp_err));
        check($sformatf("rdata d%0d a%08h", d, a), rdata[d], rd_m[d]);
        @(negedge clk);
        check($sformatf("ready_pulse d%0d", d), 32'(ready[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        r;
        int          d;
        rst_n = 1'b0;
        valid = '0; rw = '0; addr = '0; wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", 32'(ready[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rdata", rdata[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ready[0]), 32'd0);

        // Basic write/read, decode errors, zero readback.
        do_txn(0, 1'b1, 32'h10, 32'hA5A5_0001, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0);
        do_txn(0, 1'b1, 32'h102, 32'hDEAD_BEEF, 0);
        do_txn(0, 1'b1, 32'h100, 32'hCAFE_F00D, 0);
        do_txn(0, 1'b0, 32'h00, 32'h0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0);

        // Zero wait states, valid held high across five writes.
        @(negedge clk);
        valid[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h0; wdata[1] = 32'h5000_0000;
        @(posedge clk);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check($sformatf("b2b_ready%0d", j), 32'(ready[1]), 32'(j % 2));
            if (j % 2 == 1) check($sformatf("b2b_err%0d", j), 32'(err[1]), 32'd0);
            if (j % 2 == 0) begin
                if (j / 2 + 1 < 5) begin
                    addr[1]  = 32'((j / 2 + 1) * 4);
                    wdata[1] = 32'h5000_0000 + 32'(j / 2 + 1);
                end else begin
                    valid[1] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 5; k++) mem_m[1][k] = 32'h5000_0000 + 32'(k);
        @(negedge clk);
        check("b2b_tail", 32'(ready[1]), 32'd0);
        for (int k = 0; k < 5; k++) do_txn(1, 1'b0, 32'(k * 4), 32'h0, 0);

        // Inputs wiggled during the wait states must not disturb the latched request.
        do_txn(0, 1'b1, 32'h30, 32'h1234_5678, 1);
        do_txn(0, 1'b0, 32'h30, 32'h0, 1);

        // Reset in the middle of a write's wait states.
        @(negedge clk);
        valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_ready", 32'(ready[0]), 32'd0);
        end
        check("rst_rdata", rdata[0], 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_ready", 32'(ready[0]), 32'd0);
        end
        do_txn(0, 1'b0, 32'h20, 32'h0, 0);
        do_txn(0, 1'b0, 32'h10, 32'h0, 0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 40; n++) begin
            d = int'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 15)) * 4;
                2:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            do_txn(d, r, a, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
